// File: rtl/jt12_pg_seq.sv
// Phase-generator sequencer: per-slot phase and frequency storage, slot
// round-robin, key-on reset scheduling and registered operator phase output.
// The phase-sum arithmetic is done by an external combinational datapath.
module jt12_pg_seq #(
  parameter int SLOTS = 24,
  parameter int PW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          cfg_we,
  input  logic [4:0]    cfg_slot,
  input  logic [3:0]    cfg_mul,
  input  logic [5:0]    cfg_dt,
  input  logic [16:0]   cfg_phinc,
  input  logic          kon_we,
  input  logic [4:0]    kon_slot,
  output logic [3:0]    pg_mul,
  output logic [5:0]    pg_dt,
  output logic [16:0]   pg_phinc,
  output logic [PW-1:0] pg_phase_in,
  output logic          pg_rst,
  input  logic [PW-1:0] pg_phase_out,
  input  logic [9:0]    pg_phase_op,
  output logic [4:0]    cur_slot,
  output logic          slot_sync,
  output logic [9:0]    op_phase,
  output logic [4:0]    op_slot,
  output logic          op_valid
);

  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

  logic [PW-1:0] phase_reg [SLOTS];
  logic [3:0]    mul_reg   [SLOTS];
  logic [5:0]    dt_reg    [SLOTS];
  logic [16:0]   phinc_reg [SLOTS];
  logic          pend_reg  [SLOTS];

  logic [4:0]    cur_slot_reg;
  logic [9:0]    op_phase_reg;
  logic [4:0]    op_slot_reg;
  logic          op_valid_reg;

  // Per-slot storage. Slot matching is by equality against the genvar, so
  // indices at or beyond SLOTS never hit any entry and are dropped.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      logic visit;
      assign visit = cen && (cur_slot_reg == 5'(gi));

      // Phase write-back on the slot visit; config writes independent of cen.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          phase_reg[gi] <= '0;
          mul_reg[gi]   <= '0;
          dt_reg[gi]    <= '0;
          phinc_reg[gi] <= '0;
        end else begin
          if (visit)
            phase_reg[gi] <= pg_phase_out;
          if (cfg_we && (cfg_slot == 5'(gi))) begin
            mul_reg[gi]   <= cfg_mul;
            dt_reg[gi]    <= cfg_dt;
            phinc_reg[gi] <= cfg_phinc;
          end
        end
      end

      // Pending key-on flag: a new key-on wins over the clear of this visit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          pend_reg[gi] <= 1'b0;
        else if (kon_we && (kon_slot == 5'(gi)))
          pend_reg[gi] <= 1'b1;
        else if (visit)
          pend_reg[gi] <= 1'b0;
      end
    end
  endgenerate

  // Slot round-robin and registered operator phase hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_slot_reg <= '0;
      op_phase_reg <= '0;
      op_slot_reg  <= '0;
      op_valid_reg <= 1'b0;
    end else if (cen) begin
      cur_slot_reg <= (cur_slot_reg == LAST_SLOT) ? 5'd0 : cur_slot_reg + 5'd1;
      op_phase_reg <= pg_phase_op;
      op_slot_reg  <= cur_slot_reg;
      op_valid_reg <= 1'b1;
    end else begin
      op_valid_reg <= 1'b0;
    end
  end

  assign pg_mul      = mul_reg[cur_slot_reg];
  assign pg_dt       = dt_reg[cur_slot_reg];
  assign pg_phinc    = phinc_reg[cur_slot_reg];
  assign pg_phase_in = phase_reg[cur_slot_reg];
  assign pg_rst      = pend_reg[cur_slot_reg];

  assign cur_slot  = cur_slot_reg;
  assign slot_sync = (cur_slot_reg == 5'd0);
  assign op_phase  = op_phase_reg;
  assign op_slot   = op_slot_reg;
  assign op_valid  = op_valid_reg;

endmodule
